mux_scan: RTL and testbench

Parametrised N-channel, W-bit registered multiplexer with two selection modes: manual (host-loaded select) and auto-scan (round-robin channel stepping with a programmable dwell time). It succeeds the fixed 4:1 single-bit gate-level mux. Typical uses are time-multiplexing several data sources onto one output path, such as display digit scanning or round-robin sampling. The block adds a registered select, a registered output, a channel-change indication and scan wrap reporting.

---
 rtl/mux_scan.sv | 94 +++++++++
 tb/tb_mux_scan.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/mux_scan.sv
// mux_scan: N-channel, W-bit registered multiplexer.
// In manual mode the host loads the channel select. In scan mode the select
// steps round-robin through the channels and holds each one for DWELL cycles.
// The output data is registered one cycle behind cur_sel. out_valid marks the
// cycle in which out first shows a newly selected channel. wrap pulses when a
// scan rotation returns to channel 0.
module mux_scan #(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 4,
    parameter int SEL_W    = 2,
    parameter int DWELL    = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [CHANNELS*WIDTH-1:0] in_bus,
    input  logic [SEL_W-1:0]          sel,
    input  logic                      load,
    input  logic                      mode,
    output logic [WIDTH-1:0]          out,
    output logic                      out_valid,
    output logic [SEL_W-1:0]          cur_sel,
    output logic                      wrap
);

    // DWELL is at most 65535, so the dwell count (0..DWELL-1) fits in 16 bits.
    localparam int                 CNT_W     = 16;
    localparam logic [CNT_W-1:0]   CNT_LAST  = CNT_W'(DWELL - 1);
    localparam logic [SEL_W-1:0]   SEL_LAST  = SEL_W'(CHANNELS - 1);
    // One extra bit so the limit is still representable when CHANNELS == 2**SEL_W.
    localparam logic [SEL_W:0]     SEL_LIMIT = (SEL_W + 1)'(CHANNELS);

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;
    logic [SEL_W-1:0] sel_next;
    logic             wrap_next;
    logic             sel_ok;
    // Set when cur_sel took a new value at the last edge (or right after reset),
    // so out_valid drops in the cycle out first shows that channel.
    logic             changed;
    logic [WIDTH-1:0] sel_data;

    assign sel_ok = ({1'b0, sel} < SEL_LIMIT);

    // Pick the slice of in_bus addressed by the current select.
    always_comb begin
        // NOTE: every signal written in an always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
        sel_data = '0;
        for (int k = 0; k < CHANNELS; k++) begin
            if (cur_sel == SEL_W'(k)) begin
                sel_data = in_bus[k*WIDTH +: WIDTH];
            end
        end
    end

    // Next select, dwell count and wrap: a valid load beats a scheduled step.
    always_comb begin
        sel_next  = cur_sel;
        cnt_next  = '0;
        wrap_next = 1'b0;
        if (mode) begin
            if (load && sel_ok) begin
                sel_next = sel;
            end else if (cnt == CNT_LAST) begin
                sel_next  = (cur_sel == SEL_LAST) ? '0 : cur_sel + SEL_W'(1);
                wrap_next = (cur_sel == SEL_LAST);
            end else begin
                cnt_next = cnt + CNT_W'(1);
            end
        end else if (load && sel_ok) begin
            sel_next = sel;
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            cur_sel   <= '0;
            cnt       <= '0;
            out       <= '0;
            out_valid <= 1'b0;
            wrap      <= 1'b0;
            changed   <= 1'b1;
        end else begin
            cur_sel   <= sel_next;
            cnt       <= cnt_next;
            out       <= sel_data;
            out_valid <= ~changed;
            wrap      <= wrap_next;
            changed   <= (sel_next != cur_sel);
        end
    end

endmodule

// File: tb/tb_mux_scan.sv
// Testbench for mux_scan: a table of directed vectors on a 4-channel, DWELL=3
// instance, plus hand-written sequences for a 3-channel instance (out-of-range
// selects, 0,1,2,0 scan) and a DWELL=1 instance (step every cycle, out_valid low).
module tb_mux_scan;

    localparam logic [31:0] BUS0 = 32'h44332211;
    localparam logic [31:0] BUS1 = 32'h55667788;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] in_bus = BUS0;
    logic [1:0]  sel = '0;
    logic        load = 1'b0;
    logic        mode = 1'b0;

    logic [7:0]  a_out, b_out, c_out;
    logic        a_valid, b_valid, c_valid;
    logic [1:0]  a_cur, b_cur, c_cur;
    logic        a_wrap, b_wrap, c_wrap;

    int n_vec  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    mux_scan #(.WIDTH(8), .CHANNELS(4), .SEL_W(2), .DWELL(3)) dut_a (
        .clk(clk), .rst(rst), .in_bus(in_bus), .sel(sel), .load(load), .mode(mode),
        .out(a_out), .out_valid(a_valid), .cur_sel(a_cur), .wrap(a_wrap)
    );

    mux_scan #(.WIDTH(8), .CHANNELS(3), .SEL_W(2), .DWELL(2)) dut_b (
        .clk(clk), .rst(rst), .in_bus(in_bus[23:0]), .sel(sel), .load(load), .mode(mode),
        .out(b_out), .out_valid(b_valid), .cur_sel(b_cur), .wrap(b_wrap)
    );

    mux_scan #(.WIDTH(8), .CHANNELS(4), .SEL_W(2), .DWELL(1)) dut_c (
        .clk(clk), .rst(rst), .in_bus(in_bus), .sel(sel), .load(load), .mode(mode),
        .out(c_out), .out_valid(c_valid), .cur_sel(c_cur), .wrap(c_wrap)
    );

    typedef struct {
        logic        rst;
        logic        load;
        logic [1:0]  sel;
        logic        mode;
        logic [31:0] bus;
        logic [1:0]  e_sel;
        logic [7:0]  e_out;
        logic        e_valid;
        logic        e_wrap;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic r, input logic l, input logic [1:0] s, input logic m,
                       input logic [31:0] b, input logic [1:0] es, input logic [7:0] eo,
                       input logic ev, input logic ew);
        vec_t v;
        v.rst = r; v.load = l; v.sel = s; v.mode = m; v.bus = b;
        v.e_sel = es; v.e_out = eo; v.e_valid = ev; v.e_wrap = ew;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, got, exp);
        end
    endtask

    // Drive inputs away from the edge, clock once, sample 1 time unit after the edge.
    task automatic tick(input logic r, input logic l, input logic [1:0] s, input logic m);
        @(negedge clk);
        rst = r; load = l; sel = s; mode = m;
        @(posedge clk);
        #1;
    endtask

    initial begin
        //   rst ld sel md bus   cur out  vld wrp
        add(1, 0, 0, 0, BUS0, 0, 8'h00, 0, 0);  // 0  reset, bus non-zero
        add(1, 0, 0, 0, BUS0, 0, 8'h00, 0, 0);  // 1  reset second cycle
        add(0, 0, 0, 0, BUS0, 0, 8'h11, 0, 0);  // 2  first edge after release
        add(0, 0, 0, 0, BUS0, 0, 8'h11, 1, 0);  // 3  valid from second edge
        add(0, 1, 2, 0, BUS0, 2, 8'h11, 1, 0);  // 4  load sel=2
        add(0, 0, 0, 0, BUS0, 2, 8'h33, 0, 0);  // 5  out shows ch2, valid low once
        add(0, 0, 0, 0, BUS0, 2, 8'h33, 1, 0);  // 6
        add(0, 1, 2, 0, BUS0, 2, 8'h33, 1, 0);  // 7  reload same value: no change
        add(0, 0, 0, 0, BUS0, 2, 8'h33, 1, 0);  // 8
        add(0, 1, 0, 0, BUS0, 0, 8'h33, 1, 0);  // 9  load sel=0
        add(0, 0, 0, 1, BUS0, 0, 8'h11, 0, 0);  // 10 scan starts, count 0->1
        add(0, 0, 0, 1, BUS0, 0, 8'h11, 1, 0);  // 11
        add(0, 0, 0, 1, BUS0, 1, 8'h11, 1, 0);  // 12 first step, DWELL=3 edges in
        add(0, 0, 0, 1, BUS0, 1, 8'h22, 0, 0);  // 13
        add(0, 0, 0, 1, BUS0, 1, 8'h22, 1, 0);  // 14
        add(0, 0, 0, 1, BUS0, 2, 8'h22, 1, 0);  // 15
        add(0, 0, 0, 1, BUS0, 2, 8'h33, 0, 0);  // 16
        add(0, 0, 0, 1, BUS0, 2, 8'h33, 1, 0);  // 17
        add(0, 0, 0, 1, BUS0, 3, 8'h33, 1, 0);  // 18
        add(0, 0, 0, 1, BUS0, 3, 8'h44, 0, 0);  // 19
        add(0, 0, 0, 1, BUS0, 3, 8'h44, 1, 0);  // 20
        add(0, 0, 0, 1, BUS0, 0, 8'h44, 1, 1);  // 21 3->0 step, wrap pulse
        add(0, 0, 0, 1, BUS0, 0, 8'h11, 0, 0);  // 22 wrap gone
        add(0, 0, 0, 1, BUS0, 0, 8'h11, 1, 0);  // 23
        add(0, 0, 0, 1, BUS0, 1, 8'h11, 1, 0);  // 24
        add(0, 0, 0, 1, BUS0, 1, 8'h22, 0, 0);  // 25
        add(0, 0, 0, 1, BUS0, 1, 8'h22, 1, 0);  // 26
        add(0, 0, 0, 1, BUS0, 2, 8'h22, 1, 0);  // 27
        add(0, 0, 0, 1, BUS0, 2, 8'h33, 0, 0);  // 28
        add(0, 0, 0, 1, BUS0, 2, 8'h33, 1, 0);  // 29 step from 2 due next edge
        add(0, 1, 1, 1, BUS0, 1, 8'h33, 1, 0);  // 30 load sel=1 beats the step
        add(0, 0, 0, 1, BUS0, 1, 8'h22, 0, 0);  // 31 count restarted
        add(0, 0, 0, 1, BUS0, 1, 8'h22, 1, 0);  // 32
        add(0, 0, 0, 1, BUS0, 2, 8'h22, 1, 0);  // 33 step DWELL edges after jump
        add(0, 0, 0, 1, BUS0, 2, 8'h33, 0, 0);  // 34
        add(0, 0, 0, 0, BUS0, 2, 8'h33, 1, 0);  // 35 mode 1->0, holds at 2
        add(0, 0, 0, 0, BUS0, 2, 8'h33, 1, 0);  // 36
        add(0, 0, 0, 0, BUS0, 2, 8'h33, 1, 0);  // 37
        add(0, 0, 0, 0, BUS0, 2, 8'h33, 1, 0);  // 38
        add(0, 0, 0, 1, BUS0, 2, 8'h33, 1, 0);  // 39 scan again, count 0->1
        add(1, 0, 0, 1, BUS0, 0, 8'h00, 0, 0);  // 40 reset mid-dwell
        add(0, 0, 0, 1, BUS0, 0, 8'h11, 0, 0);  // 41 release with mode=1
        add(0, 0, 0, 1, BUS0, 0, 8'h11, 1, 0);  // 42
        add(0, 0, 0, 1, BUS0, 1, 8'h11, 1, 0);  // 43 first step DWELL edges after release
        add(0, 0, 0, 1, BUS0, 1, 8'h22, 0, 0);  // 44
        add(0, 0, 0, 0, BUS0, 1, 8'h22, 1, 0);  // 45 manual, hold
        add(0, 0, 0, 0, BUS1, 1, 8'h77, 1, 0);  // 46 in_bus change: out follows, valid stays

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            rst = vecs[i].rst; load = vecs[i].load; sel = vecs[i].sel;
            mode = vecs[i].mode; in_bus = vecs[i].bus;
            @(posedge clk);
            #1;
            check($sformatf("a v%0d cur_sel", i), 32'(a_cur), 32'(vecs[i].e_sel));
            check($sformatf("a v%0d out", i), 32'(a_out), 32'(vecs[i].e_out));
            check($sformatf("a v%0d out_valid", i), 32'(a_valid), 32'(vecs[i].e_valid));
            check($sformatf("a v%0d wrap", i), 32'(a_wrap), 32'(vecs[i].e_wrap));
        end

        // Three channels: sel=3 is out of range in both modes; scan runs 0,1,2,0.
        in_bus = BUS0;
        tick(1, 0, 0, 0);
        check("b reset cur_sel", 32'(b_cur), 32'd0);
        check("b reset out", 32'(b_out), 32'h00);
        check("b reset out_valid", 32'(b_valid), 32'd0);
        tick(0, 1, 1, 0);
        check("b load 1", 32'(b_cur), 32'd1);
        tick(0, 1, 3, 0);
        check("b load 3 ignored", 32'(b_cur), 32'd1);
        check("b out ch1", 32'(b_out), 32'h22);
        tick(0, 0, 0, 1);
        check("b scan hold", 32'(b_cur), 32'd1);
        tick(0, 0, 0, 1);
        check("b step to 2", 32'(b_cur), 32'd2);
        check("b no wrap at 2", 32'(b_wrap), 32'd0);
        tick(0, 0, 0, 1);
        check("b hold 2", 32'(b_cur), 32'd2);
        tick(0, 0, 0, 1);
        check("b step 2 to 0", 32'(b_cur), 32'd0);
        check("b wrap", 32'(b_wrap), 32'd1);
        tick(0, 0, 0, 1);
        check("b wrap one cycle", 32'(b_wrap), 32'd0);
        check("b out ch0", 32'(b_out), 32'h11);
        tick(0, 0, 0, 1);
        check("b step to 1", 32'(b_cur), 32'd1);
        tick(0, 0, 0, 1);
        check("b hold 1", 32'(b_cur), 32'd1);
        tick(0, 1, 3, 1);
        check("b scan load 3 still steps", 32'(b_cur), 32'd2);
        tick(0, 0, 0, 1);
        check("b out ch2", 32'(b_out), 32'h33);

        // DWELL=1: a step on every edge and out_valid held low while scanning.
        tick(1, 0, 0, 0);
        check("c reset cur_sel", 32'(c_cur), 32'd0);
        for (int i = 0; i < 8; i++) begin
            tick(0, 0, 0, 1);
            check($sformatf("c step %0d cur_sel", i), 32'(c_cur), 32'((i + 1) % 4));
            check($sformatf("c step %0d out_valid", i), 32'(c_valid), 32'd0);
            check($sformatf("c step %0d wrap", i), 32'(c_wrap), 32'(((i + 1) % 4) == 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
